// File: rtl/hex_sr_pkg.sv
// Shared op encodings and controller states for the hex shift-register store.
package hex_sr_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        CLEAR,
        DONE
    } state_e;

endpackage

// File: rtl/hex_sr_ctrl_if.sv
// Request/response handshake between the I/O decode and the store controller.
interface hex_sr_ctrl_if
    import hex_sr_pkg::*;
#(
    parameter int AW = 7
);
    logic          req_valid;
    logic          req_ready;
    op_e           req_op;
    logic [AW-1:0] req_addr;
    logic [5:0]    req_wdata;
    logic          rsp_valid;
    logic [5:0]    rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/hex_sr_pos_ctr.sv
// Modulo-LENGTH counter with enable and synchronous clear.
module hex_sr_pos_ctr #(
    parameter  int LENGTH = 100,
    localparam int AW     = $clog2(LENGTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] pos
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (clr) begin
            pos <= '0;
        end else if (en) begin
            pos <= (pos == AW'(LENGTH - 1)) ? '0 : pos + AW'(1);
        end
    end

endmodule

// File: rtl/hex_sr_ctrl.sv
// Rotates the recirculating hex shift register to make it an addressable store.
module hex_sr_ctrl
    import hex_sr_pkg::*;
#(
    parameter int LENGTH = 100
) (
    input  logic         clk,
    input  logic         rst_n,
    hex_sr_ctrl_if.slave bus,
    output logic         sr_shift,
    output logic         sr_recirc,
    output logic [5:0]   sr_din,
    input  logic [5:0]   sr_dout
);

    localparam int AW = $clog2(LENGTH);

    state_e        state;
    op_e           op;
    logic [AW-1:0] addr;
    logic [5:0]    wdata;
    logic [AW-1:0] pos;
    logic [AW-1:0] clr_cnt;

    logic accept;
    logic oob;
    logic bad;
    logic hit;
    logic wr_hit;
    logic last;

    assign accept = bus.req_valid && (state == IDLE);
    assign oob    = {1'b0, bus.req_addr} >= (AW+1)'(LENGTH);
    assign bad    = (bus.req_op == OP_RSVD) ||
                    ((bus.req_op != OP_CLEAR) && oob);
    assign hit    = (pos == addr);
    assign wr_hit = (state == SEEK) && hit && (op == OP_WRITE);
    assign last   = (clr_cnt == AW'(LENGTH - 1));

    assign sr_shift  = (state == SEEK) || (state == CLEAR);
    assign sr_recirc = !((state == CLEAR) || wr_hit);
    assign sr_din    = wr_hit ? wdata : 6'd0;

    hex_sr_pos_ctr #(.LENGTH(LENGTH)) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (sr_shift),
        .pos   (pos)
    );

    // A clear sweeps exactly LENGTH cells, so pos returns to its start.
    hex_sr_pos_ctr #(.LENGTH(LENGTH)) u_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == CLEAR),
        .pos   (clr_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op            <= OP_READ;
            addr          <= '0;
            wdata         <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op            <= bus.req_op;
                        addr          <= bus.req_addr;
                        wdata         <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (bad) begin
                            state         <= DONE;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                        end else if (bus.req_op == OP_CLEAR) begin
                            state <= CLEAR;
                        end else begin
                            state <= SEEK;
                        end
                    end
                end
                SEEK: begin
                    if (hit) begin
                        if (op == OP_READ) begin
                            bus.rsp_rdata <= sr_dout;
                        end
                        state         <= DONE;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (last) begin
                        state         <= DONE;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_sr_ctrl.sv
// Bench for hex_sr_ctrl: behavioural array plus a logical word-store model.
module tb_hex_sr_ctrl;
    import hex_sr_pkg::*;

    localparam int L  = 100;
    localparam int AW = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sr_shift;
    logic       sr_recirc;
    logic [5:0] sr_din;
    logic [5:0] sr_dout;

    hex_sr_ctrl_if #(.AW(AW)) bus ();

    hex_sr_ctrl #(.LENGTH(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sr_shift  (sr_shift),
        .sr_recirc (sr_recirc),
        .sr_din    (sr_din),
        .sr_dout   (sr_dout)
    );

    always #5 clk = ~clk;

    // Physical array: circular buffer, head index h is the tail cell.
    logic [5:0] arr [L];
    int         h = 0;
    bit         seeded = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            foreach (arr[i]) arr[i] <= 6'($urandom);
            seeded <= 1'b1;
        end else if (sr_shift) begin
            arr[h] <= sr_recirc ? arr[h] : sr_din;
            h      <= (h + 1) % L;
        end
    end

    assign sr_dout = arr[h];

    int tests = 0;
    int fails = 0;
    int ref_mem [L];
    bit known [L];
    int ref_pos = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at a negedge where a new request may start.
    task automatic run(input int op, input int addr, input int wd);
        int d, exp_lat, exp_sh, n, sh;
        bit bad, got;
        bad     = (op == 3) || (op != 2 && addr >= L);
        d       = bad ? 0 : ((addr - ref_pos + L) % L);
        exp_lat = bad ? 1 : (op == 2 ? L + 1 : d + 2);
        exp_sh  = bad ? 0 : (op == 2 ? L : d + 1);
        chk("ready_before", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op_e'(op);
        bus.req_addr  = AW'(addr);
        bus.req_wdata = 6'(wd);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0; sh = 0; got = 1'b0;
        while (!got && n < L + 10) begin
            @(negedge clk);
            n++;
            if (sr_shift) sh++;
            if (bus.rsp_valid) got = 1'b1;
        end
        chk("latency", n, exp_lat);
        chk("rsp_err", 32'(bus.rsp_err), 32'(bad));
        chk("shifts", sh, exp_sh);
        if (!bad && op == 0 && known[addr])
            chk("rdata", 32'(bus.rsp_rdata), ref_mem[addr]);
        if (!bad) begin
            if (op == 1) begin
                ref_mem[addr] = wd;
                known[addr]   = 1'b1;
            end
            if (op == 2) begin
                foreach (ref_mem[i]) begin
                    ref_mem[i] = 0;
                    known[i]   = 1'b1;
                end
            end
            if (op < 2) ref_pos = (addr + 1) % L;
        end
        chk("pos", 32'(dut.pos), ref_pos);
        @(negedge clk);
        chk("strobe_once", 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        int op, addr, wd;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_READ;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        foreach (known[i]) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_err", 32'(bus.rsp_err), 0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_shift", 32'(sr_shift), 0);
        chk("rst_recirc", 32'(sr_recirc), 1);
        chk("rst_din", 32'(sr_din), 0);
        chk("rst_pos", 32'(dut.pos), 0);
        @(negedge clk);

        run(1, 5, 6'h2A);
        run(0, 5, 0);
        chk("read5", 32'(bus.rsp_rdata), 6'h2A);
        run(0, 6, 0);
        run(2, 0, 0);
        run(0, 5, 0);
        chk("read5_cleared", 32'(bus.rsp_rdata), 0);
        run(0, 100, 0);
        run(3, 7, 0);
        run(1, 0, 6'h11);
        run(0, 99, 0);
        run(0, 0, 0);

        for (int k = 0; k < 30; k++) begin
            op   = int'($urandom_range(0, 3));
            addr = int'($urandom_range(0, 109));
            wd   = int'($urandom_range(0, 63));
            if (op == 3 && $urandom_range(0, 1) == 0) op = 1;
            run(op, addr, wd);
        end

        // Abort a read mid-rotation.
        chk("ready_abort", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_READ;
        bus.req_addr  = AW'(90);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.req_ready), 1);
        chk("abort_valid", 32'(bus.rsp_valid), 0);
        chk("abort_shift", 32'(sr_shift), 0);
        chk("abort_recirc", 32'(sr_recirc), 1);
        chk("abort_din", 32'(sr_din), 0);
        chk("abort_pos", 32'(dut.pos), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(bus.rsp_valid), 0);
        end
        rst_n   = 1'b1;
        ref_pos = 0;
        foreach (known[i]) known[i] = 1'b0;
        run(1, 42, 6'h15);
        run(0, 42, 0);
        run(1, 99, 6'h3F);
        run(0, 99, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_sr_ctrl.md
# hex_sr_ctrl

Access controller for the 6-bit-wide, LENGTH-deep recirculating hex shift register, turning it into a small addressable word store. Tracks which logical word sits at the shift-register output and rotates the register until the requested word arrives there. Performs read, write or clear-all under a valid/ready request and a one-cycle response strobe. Sits between the tile's I/O decode and the shift-register array; it is the only driver of the array's shift, recirc and data-in lines.

## Interface
Parameters:
- `LENGTH`, 100: words in the shift register; legal range is 2 or more.
- `AW`, derived localparam `$clog2(LENGTH)`: address and position width.

Ports:
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept; a request transfers when valid and ready are both high at a rising edge.
- `req_op`  in  2: 00 read, 01 write, 10 clear-all, 11 reserved.
- `req_addr`  in  AW: word address; ignored for clear.
- `req_wdata`  in  6: write data.
- `rsp_valid`  out  1: one-cycle completion strobe; there is no back-pressure.
- `rsp_rdata`  out  6: read data, valid with `rsp_valid` for reads; holds its last value otherwise.
- `rsp_err`  out  1: valid with `rsp_valid`; 1 means the request was rejected.
- `sr_shift`  out  1: shift enable to the array.
- `sr_recirc`  out  1: 1 feeds the tail back to the head; 0 loads `sr_din`.
- `sr_din`  out  6: data into the array head.
- `sr_dout`  in  6: array tail, which is the word at position `pos`.

## Operation
- Internal `pos`, AW bits: logical address of the word at `sr_dout`. Increments by 1 on every cycle with `sr_shift`=1 and wraps from LENGTH-1 to 0.
- States and transitions:
  - IDLE: `req_ready`=1. On accept, latch op, addr and wdata.
    - Reserved op, or read/write with addr ≥ LENGTH: go to DONE with the error flag set.
    - Clear: go to CLEAR with a clear counter set to 0.
    - Otherwise: go to SEEK.
  - SEEK: if `pos`≠addr, shift with `sr_recirc`=1 and stay. If `pos`==addr, perform the access shift this cycle, then go to DONE.
    - Read access: `sr_recirc`=1; register `rsp_rdata` ← `sr_dout`.
    - Write access: `sr_recirc`=0, `sr_din`=wdata.
  - CLEAR: shift with `sr_recirc`=0 and `sr_din`=0 for LENGTH cycles, then go to DONE. `pos` ends where it started.
  - DONE: `rsp_valid`=1, `rsp_err` = error flag, `req_ready`=0. Next state is IDLE.
- `sr_shift`, `sr_recirc` and `sr_din` are combinational decodes of state, the latched op and (`pos`==addr). Outside a shift: `sr_recirc`=1, `sr_din`=0.
- Outside DONE: `rsp_valid`=0 and `rsp_err`=0.
- A write replaces exactly word `addr`; all other words are preserved.
- The shift-register array has no reset. After `rst_n`, contents are undefined relative to `pos` until a clear or a full set of writes.

## Timing
- Reset values:
  - State IDLE, `pos`=0.
  - `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `sr_shift`=0, `sr_recirc`=1, `sr_din`=0.
- Notation: request accepted in cycle T; d = (addr − `pos`) mod LENGTH, with `pos` sampled at T.
  - Read/write: rotation shifts in T+1..T+d, access shift in T+d+1, `rsp_valid` in T+d+2, `req_ready` in T+d+3.
    - Minimum latency (d=0): `rsp_valid` at T+2. Maximum: T+LENGTH+1.
    - After completion, `pos` = addr+1 mod LENGTH.
  - Clear: shifts in T+1..T+LENGTH, `rsp_valid` in T+LENGTH+1.
  - Error: `rsp_valid` with `rsp_err`=1 in T+1; no shift occurs.
- `req_ready` is low in SEEK, CLEAR and DONE; a request held during these cycles is accepted at the first IDLE edge.
- Address compare covers the wrap case, e.g. `pos`=LENGTH-1 with addr=0 gives d=1.
- Reset asserted mid-operation: all outputs take their reset values immediately. No response is issued for the aborted request. Any partial clear or write is abandoned.

## Structure
- Package `hex_sr_pkg`: op encodings (OP_READ, OP_WRITE, OP_CLEAR, OP_RSVD) and the state enum (IDLE, SEEK, CLEAR, DONE).
- One sub-module, `hex_sr_pos_ctr`: modulo-LENGTH counter with enable, asynchronous active-low reset and a `pos` output. Instantiated once for `pos`; the clear counter reuses it.

## Test plan
Bench model: a 100×6 behavioural recirculating shift register driven by `sr_*`; LENGTH=100.
- Reset: release `rst_n` → `req_ready`=1, `rsp_valid`=0, `sr_shift`=0, `sr_recirc`=1, `pos`=0.
- Write addr 5, data 0x2A from `pos`=0 (T) → five recirculating shifts, write shift at T+6, `rsp_valid` at T+7 with `rsp_err`=0, `pos`=6.
- Read addr 5 immediately after (d=99) → `rsp_valid` at T+101, `rsp_rdata`=0x2A, `pos`=6. Then read addr 6 → d=0, response at T+2.
- Clear → 100 zero-load shifts, response at T+101, `pos` unchanged. Reading addr 5 then returns 0x00.
- Read addr 100 and op 11 → each gives `rsp_err`=1 at T+1, no `sr_shift`, `pos` unchanged.
- Assert `rst_n` low during SEEK of a read at addr 90 → outputs reset the same cycle, no `rsp_valid` is issued, and the next request is accepted at the first cycle after release.
